// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, tick divider math and legal parameter ranges for uart_core
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int OVERSAMPLE_MIN = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
        longint den;
        den = longint'(baud_rate) * longint'(oversample);
        return int'((longint'(clk_freq) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider producing a 1-cycle tick every DIV clocks
//   clk  : system clock
//   nrst : asynchronous active-low reset
//   tick : 1-cycle pulse every DIV clocks
module uart_tick_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);
    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == LAST;

    always_comb cnt_d = tick ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with valid/ready host streams and mid-bit oversampled RX
//   Host TX : tx_data/tx_valid/tx_ready, tx_busy while a frame is on the line
//   Host RX : rx_data/rx_valid/rx_ready, one-cycle rx_frame_err/rx_parity_err/rx_overrun pulses
//   Line    : tx (idle high), rx (asynchronous, synchronised internally)
//   Build   : define UART_PARITY_EN to add a parity bit and the parity_odd port
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
`ifdef UART_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 tx
);
    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID_LAST  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE % 2 != 0) begin : g_param_check
        $error("uart_core: illegal DATA_BITS, STOP_BITS or OVERSAMPLE");
    end

    logic tick;

    uart_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .tick (tick)
    );

    // ---------------- transmitter ----------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_tcnt_q, tx_tcnt_d;
    logic [3:0]           tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_bit_end = tick && tx_tcnt_q == BIT_LAST;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_state_q <= IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // The bit-time counter restarts at the handshake; the shared tick is not
    // realigned, so only the first tick of the start bit jitters.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_bit_end ? '0 : tx_tcnt_q + CW'(tick);
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            IDLE: if (tx_valid) begin
                tx_state_d = START;
                tx_tcnt_d  = '0;
                tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
                tx_par_d   = ^tx_data ^ parity_odd;
`endif
            end
            START: if (tx_bit_end) begin
                tx_state_d = DATA;
                tx_bcnt_d  = '0;
            end
            DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bcnt_d  = tx_bcnt_q + 4'd1;
                if (tx_bcnt_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    tx_state_d = PARITY;
`else
                    tx_state_d = STOP;
`endif
                    tx_bcnt_d  = '0;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tx_bit_end) tx_state_d = STOP;
`endif
            STOP: if (tx_bit_end) begin
                tx_bcnt_d = tx_bcnt_q + 4'd1;
                if (tx_bcnt_q == STOP_LAST) tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so tx is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        if (tx_state_d == START) tx_d = 1'b0;
        if (tx_state_d == DATA)  tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
        if (tx_state_d == PARITY) tx_d = tx_par_d;
`endif
    end

    assign tx       = tx_q;
    assign tx_ready = tx_state_q == IDLE;
    assign tx_busy  = tx_state_q != IDLE;

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q;
    uart_state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_tcnt_q, rx_tcnt_d;
    logic [3:0]           rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_brk_q, rx_brk_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_sample, rx_done, rx_good, rx_load;
`ifdef UART_PARITY_EN
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_perr_out_q, rx_perr_out_d;
`endif

    assign rx_sample = tick && rx_tcnt_q == BIT_LAST;
    assign rx_done   = rx_state_q == STOP && rx_sample;
    assign rx_good   = rx_done && rx_s2_q;
    assign rx_load   = rx_good && (!rx_valid_q || rx_ready);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_state_q    <= IDLE;
            rx_tcnt_q     <= '0;
            rx_bcnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_brk_q      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_ovr_q      <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q     <= 1'b0;
            rx_perr_out_q <= 1'b0;
`endif
        end else begin
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            rx_state_q    <= rx_state_d;
            rx_tcnt_q     <= rx_tcnt_d;
            rx_bcnt_q     <= rx_bcnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_brk_q      <= rx_brk_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_ovr_q      <= rx_ovr_d;
`ifdef UART_PARITY_EN
            rx_perr_q     <= rx_perr_d;
            rx_perr_out_q <= rx_perr_out_d;
`endif
        end
    end

    // The detecting tick counts as tick 0, so START begins at 1 and the
    // glitch check lands on tick OVERSAMPLE/2-1. A framing error latches
    // rx_brk until the line returns high so a held break reports once.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = tick ? rx_tcnt_q + CW'(1) : rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_brk_d   = rx_brk_q && !rx_s2_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        case (rx_state_q)
            IDLE: if (tick && !rx_s2_q && !rx_brk_q) begin
                rx_state_d = START;
                rx_tcnt_d  = CW'(1);
            end
            START: if (tick && rx_tcnt_q == MID_LAST) begin
                rx_state_d = rx_s2_q ? IDLE : DATA;
                rx_tcnt_d  = '0;
                rx_bcnt_d  = '0;
            end
            DATA: if (rx_sample) begin
                rx_tcnt_d  = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bcnt_d  = rx_bcnt_q + 4'd1;
`ifdef UART_PARITY_EN
                if (rx_bcnt_q == DATA_LAST) rx_state_d = PARITY;
`else
                if (rx_bcnt_q == DATA_LAST) rx_state_d = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (rx_sample) begin
                rx_tcnt_d  = '0;
                rx_perr_d  = rx_s2_q ^ ^rx_shift_q ^ parity_odd;
                rx_state_d = STOP;
            end
`endif
            STOP: if (rx_sample) begin
                rx_state_d = IDLE;
                rx_brk_d   = !rx_s2_q;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // A consumer pop in the completion cycle frees the slot, so the new
    // byte loads without an overrun.
    always_comb begin
        rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
        rx_valid_d = rx_load || (rx_valid_q && !rx_ready);
        rx_ferr_d  = rx_done && !rx_s2_q;
        rx_ovr_d   = rx_good && rx_valid_q && !rx_ready;
`ifdef UART_PARITY_EN
        rx_perr_out_d = rx_good && rx_perr_q;
`endif
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_out_q;
`else
    assign rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scoreboard bench for uart_core (TX waveform, loopback, error and glitch cases)
module tb_uart_core;
    localparam int DIV = 4;          // round(6e6 / (100e3 * 16)) = round(3.75)
    localparam int BIT = 16 * DIV;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_frame_err, rx_parity_err, rx_overrun;
    logic       tx_busy, tx, rx;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;
`ifdef UART_PARITY_EN
    logic       parity_odd = 1'b0;
    logic       par_flip = 1'b0;
`endif

    int n_checks = 0, n_errs = 0;
    int n_rx = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic [7:0] exp_q[$];

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(
        .CLK_FREQ   (6_000_000),
        .BAUD_RATE  (100_000),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
`ifdef UART_PARITY_EN
        .parity_odd    (parity_odd),
`endif
        .tx_busy       (tx_busy),
        .rx            (rx),
        .tx            (tx)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 40 * BIT) begin
            cycles(1);
            t++;
        end
        if (!tx_ready) check("tx_ready_timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
    endtask

    task automatic inject(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            cycles(BIT);
        end
`ifdef UART_PARITY_EN
        rx_drv = ^b ^ parity_odd ^ par_flip;
        cycles(BIT);
`endif
        rx_drv = stop;
        cycles(BIT);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 40 * BIT) begin
            cycles(1);
            t++;
        end
        check("scoreboard_drain", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rx_frame_err) n_ferr++;
        if (rx_parity_err) n_perr++;
        if (rx_overrun) n_ovr++;
        if (rx_valid && rx_ready) begin
            n_rx++;
            if (exp_q.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       wav[$];
        logic [10:0] fb;
        logic [7:0]  b;
        int n, start, r0, f0, p0, o0;

        cycles(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_err_pulses", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
        nrst = 1'b1;
        cycles(5);

        // TX waveform of 0xA5
        b = 8'hA5;
`ifdef UART_PARITY_EN
        fb = {1'b1, ^b, b};
`else
        fb = {2'b11, b};
`endif
        send_byte(b);
        check("tx_busy_in_frame", {31'd0, tx_busy}, 32'd1);
        n = 0;
        while (!tx_ready && n < 20 * BIT) begin
            wav.push_back(tx);
            cycles(1);
            n++;
        end
        start = 0;
        while (start < n && wav[start] == 1'b0) start++;
        check("tx_start_len", {31'd0, start > BIT - DIV && start <= BIT}, 32'd1);
        check("tx_ready_low_len", n, start + (NB - 1) * BIT);
        for (int i = 0; i < NB - 1; i++) begin
            if (start + i * BIT + BIT - 1 < n)
                check($sformatf("tx_bit%0d", i), {30'd0, wav[start + i * BIT], wav[start + i * BIT + BIT - 1]}, {30'd0, fb[i], fb[i]});
            else
                check($sformatf("tx_bit%0d_missing", i), n, start + (NB - 1) * BIT);
        end

        // Loopback of random bytes
        loop = 1'b1;
        cycles(2);
        r0 = n_rx; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b);
        end
        wait_drain();
        cycles(BIT);
        check("loop_count", n_rx - r0, 32'd64);
        check("loop_err_pulses", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        loop = 1'b0;
        cycles(2 * BIT);

        // Framing error followed by a break, then a good byte
        r0 = n_rx; f0 = n_ferr;
        inject(8'h55, 1'b0);
        rx_drv = 1'b0;
        cycles(3 * BIT);
        rx_drv = 1'b1;
        cycles(2 * BIT);
        check("frame_err_count", n_ferr - f0, 32'd1);
        check("frame_err_no_rx", n_rx - r0, 32'd0);
        check("frame_err_rx_valid", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back(8'h12);
        inject(8'h12, 1'b1);
        rx_drv = 1'b1;
        wait_drain();
        check("after_break_ferr", n_ferr - f0, 32'd1);

        // Overrun with the consumer stalled
        cycles(BIT);
        o0 = n_ovr;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        inject(8'h11, 1'b1);
        inject(8'h22, 1'b1);
        rx_drv = 1'b1;
        cycles(BIT);
        check("ovr_count", n_ovr - o0, 32'd1);
        check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_rx_data", {24'd0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        wait_drain();
        cycles(2);
        check("ovr_drained_valid", {31'd0, rx_valid}, 32'd0);

`ifdef UART_PARITY_EN
        // Even parity, wrong parity bit (1) on 0x03
        cycles(BIT);
        p0 = n_perr;
        parity_odd = 1'b0;
        par_flip = 1'b1;
        exp_q.push_back(8'h03);
        inject(8'h03, 1'b1);
        par_flip = 1'b0;
        rx_drv = 1'b1;
        wait_drain();
        check("parity_err_count", n_perr - p0, 32'd1);
`endif

        // Short low glitch, then recovery
        cycles(BIT);
        r0 = n_rx; f0 = n_ferr;
        rx_drv = 1'b0;
        cycles(4 * DIV);
        rx_drv = 1'b1;
        cycles(3 * BIT);
        check("glitch_no_rx", n_rx - r0, 32'd0);
        check("glitch_no_ferr", n_ferr - f0, 32'd0);
        exp_q.push_back(8'h3C);
        inject(8'h3C, 1'b1);
        rx_drv = 1'b1;
        wait_drain();

        // Reset in the middle of a TX frame
        send_byte(8'hF0);
        cycles(3 * BIT);
        check("mid_frame_busy", {31'd0, tx_busy}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_mid_tx_busy", {31'd0, tx_busy}, 32'd0);
        cycles(2);
        nrst = 1'b1;
        cycles(4);
        check("post_rst_tx", {31'd0, tx}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
